// File: rtl/csa_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csa_seq_ctrl (with helper slice csa_4)
// Purpose  : Nibble-serial W-bit adder. One 4-bit carry-select slice (csa_4)
//            is time-shared across the operand, LSB nibble first, one nibble
//            per clock. A three-state controller (IDLE/RUN/DONE) handles the
//            operand handshake and holds the result until it is consumed.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports (csa_seq_ctrl), W = 4*NIB:
//   clk        in   1  clock, rising-edge active
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  operand request valid
//   in_ready   out  1  controller idle, request will be taken
//   a, b       in   W  operands
//   c_in       in   1  carry into nibble 0
//   out_valid  out  1  result valid (DONE)
//   out_ready  in   1  consumer takes the result
//   sum        out  W  (a + b + c_in) mod 2^W
//   c_out      out  1  carry out of the top nibble
//   ovf        out  1  two's-complement overflow
//   busy       out  1  operation in progress or result pending
// ============================================================================
module csa_seq_ctrl #(
  parameter int NIB = 4                       // nibbles per operand, 1..16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4*NIB-1:0] a,
  input  logic [4*NIB-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4*NIB-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int W  = 4 * NIB;
  // Wide enough to hold NIB, so the terminal compare never aliases.
  localparam int IW = (NIB < 2) ? 1 : $clog2(NIB + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic [W-1:0]    sum_d;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic            c_out_q;
  logic            ovf_q;
  logic            ovf_d;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [3:0]      w_a_nib;
  logic [3:0]      w_b_nib;
  logic [3:0]      w_slice_sum;
  logic            w_slice_cout;

  // Operand nibble select. A compare-per-nibble mux keeps every index
  // in range even when NIB is not a power of two.
  always_comb begin
    w_a_nib = 4'h0;
    w_b_nib = 4'h0;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IW'(n)) begin
        w_a_nib = a_q[n*4 +: 4];
        w_b_nib = b_q[n*4 +: 4];
      end
    end
  end

  csa_4 u_slice (
    .a_i   (w_a_nib),
    .b_i   (w_b_nib),
    .c_i   (carry_q),
    .sum_o (w_slice_sum),
    .c_o   (w_slice_cout)
  );

  // Sum register with the current nibble replaced by the slice result.
  // Kept in a separate block from the operand mux so the slice path is not
  // seen as a loop through one process.
  always_comb begin
    sum_d = sum_q;
    for (int n = 0; n < NIB; n++) begin
      if (idx_q == IW'(n)) begin
        sum_d[n*4 +: 4] = w_slice_sum;
      end
    end
  end

  // Overflow uses the MSB of the completed sum, valid on the final RUN edge.
  assign ovf_d = (a_q[W-1] == b_q[W-1]) && (sum_d[W-1] != a_q[W-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q         <= a;
            b_q         <= b;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= c_in;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
            state_q     <= S_RUN;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        S_RUN: begin
          sum_q   <= sum_d;
          carry_q <= w_slice_cout;
          if (idx_q == LAST_IDX) begin
            // idx stays on the last nibble rather than stepping past it.
            c_out_q     <= w_slice_cout;
            ovf_q       <= ovf_d;
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// ============================================================================
// Module   : csa_4
// Purpose  : 4-bit carry-select adder slice. The low 2-bit pair ripples from
//            c_i; the high pair is computed speculatively for carry 0 and 1
//            and the low-pair carry picks the result.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports:
//   a_i, b_i  in   4  addends
//   c_i       in   1  carry in
//   sum_o     out  4  a_i + b_i + c_i (low 4 bits)
//   c_o       out  1  carry out
// ============================================================================
module csa_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] sum_o,
  output logic       c_o
);

  logic [2:0] w_lo;
  logic [2:0] w_hi [2];

  assign w_lo = {1'b0, a_i[1:0]} + {1'b0, b_i[1:0]} + {2'b00, c_i};

  // Speculative upper pair: entry k assumes carry-in k.
  for (genvar k = 0; k < 2; k++) begin : g_spec
    assign w_hi[k] = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]} + 3'(k);
  end

  assign sum_o = {(w_lo[2] ? w_hi[1][1:0] : w_hi[0][1:0]), w_lo[1:0]};
  assign c_o   = w_lo[2] ? w_hi[1][2] : w_hi[0][2];

endmodule
`default_nettype wire

// File: tb/tb_csa_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csa_seq_ctrl
// Purpose  : Scoreboard bench for csa_seq_ctrl (NIB=4). The stimulus process
//            pushes hand-computed results at each accept; a monitor pops and
//            compares on every result handshake and checks result latency.
// Revision : 1.0  initial release
// ============================================================================
module tb_csa_seq_ctrl;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         busy;

  csa_seq_ctrl #(.NIB(NIB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   stim_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Present a request, wait (bounded) for in_ready, and on the accept edge
  // optionally push the expected result. Live inputs are scrambled afterwards.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input logic tc, input logic [W-1:0] es,
                       input logic eco, input logic eov, input bit push);
    int   tries;
    exp_t e;
    @(posedge clk); #1;
    in_valid = 1'b1; a = ta; b = tb_; c_in = tc;
    tries = 0;
    while (!in_ready && tries < 50) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!in_ready) timeout_fail("issue_in_ready");
    @(posedge clk); #1;
    if (push) begin
      e.s = es; e.co = eco; e.ov = eov; e.acc = cyc;
      sbq.push_back(e);
    end
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; c_in = ~tc;
  endtask

  task automatic wait_idle();
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (in_ready) seen = 1'b1;
    end
    if (!seen) timeout_fail("wait_idle");
  endtask

  // Monitor: latency on the rising edge of out_valid, data on handshake.
  initial begin
    logic prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev_ov) begin
        if (sbq.size() > 0) chk("latency", 32'(cyc - sbq[0].acc), 32'(NIB));
        else timeout_fail("unexpected_out_valid");
      end
      if (out_valid && out_ready) begin
        if (sbq.size() > 0) begin
          exp_t e;
          e = sbq.pop_front();
          chk("sum",   32'(sum),   32'(e.s));
          chk("c_out", 32'(c_out), 32'(e.co));
          chk("ovf",   32'(ovf),   32'(e.ov));
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    // Reset held with a live request: nothing may be taken.
    rst = 1'b1; in_valid = 1'b1; a = 16'h1234; b = 16'h4321; c_in = 1'b0;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'h0);
      chk("rst_sum",       32'(sum),       32'h0);
      chk("rst_busy",      32'(busy),      32'h0);
      chk("rst_in_ready",  32'(in_ready),  32'h1);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    begin
      exp_t e;
      e.s = 16'h5555; e.co = 1'b0; e.ov = 1'b0; e.acc = cyc;
      sbq.push_back(e);
    end
    chk("first_accept_busy", 32'(busy), 32'h1);
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; c_in = 1'b1;
    wait_idle();

    // Directed vectors: full ripple, overflow, mixed.
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); wait_idle();
    issue(16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1); wait_idle();
    issue(16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b1); wait_idle();
    issue(16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, 1'b0, 1'b1); wait_idle();
    issue(16'h5000, 16'h3000, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1); wait_idle();

    // Backpressure: result held while a new request is ignored.
    out_ready = 1'b0;
    issue(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
      end
      if (!seen) timeout_fail("bp_out_valid");
    end
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; c_in = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_sum",      32'(sum),       32'h0000);
      chk("bp_c_out",    32'(c_out),     32'h1);
      chk("bp_ovf",      32'(ovf),       32'h1);
      chk("bp_in_ready", 32'(in_ready),  32'h0);
      chk("bp_valid",    32'(out_valid), 32'h1);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    begin
      exp_t e;
      e.s = 16'h3333; e.co = 1'b0; e.ov = 1'b0; e.acc = cyc;
      sbq.push_back(e);
    end
    chk("bp_new_accept_busy", 32'(busy), 32'h1);
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    wait_idle();

    // Reset two edges into RUN aborts the operation at once.
    issue(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk); #1;
    chk("mid_run_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'h0);
    chk("abort_sum",       32'(sum),       32'h0);
    chk("abort_c_out",     32'(c_out),     32'h0);
    chk("abort_busy",      32'(busy),      32'h0);
    chk("abort_in_ready",  32'(in_ready),  32'h1);
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    issue(16'h0008, 16'h0008, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b1); wait_idle();

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sbq.size()), 32'h0);
    stim_done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    if (!stim_done) begin
      $display("FAIL watchdog: simulation did not complete, %0d of %0d compares failed", n_err, n_vec);
      $fatal(1, "watchdog expired");
    end
  end

endmodule
`default_nettype wire
